// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Define ID_EX_FORWARD_EN to enable forwarding; otherwise RAW hazards stall until write-back.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [2:0]  id_alu_ctl,
  input  logic        id_alusrc,
  input  logic        id_regdst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        flush,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic        stall,
  output logic        ex_valid,
  output logic [2:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg
);

  localparam logic [2:0] AluAdd = 3'b010;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr_reg;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [2:0]  alu_ctl;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
  } stage_t;

  stage_t      stage_d, stage_q;
  logic        bubble;
  logic [31:0] fwd_rs, fwd_rt;

  assign bubble = flush | stall | ~id_valid;

  always_comb begin
    stage_d = stage_q;
    if (bubble) begin
      // Data fields hold; only the parts that can cause side effects are cleared.
      stage_d.valid    = 1'b0;
      stage_d.alu_ctl  = AluAdd;
      stage_d.alusrc   = 1'b0;
      stage_d.regwrite = 1'b0;
      stage_d.memread  = 1'b0;
      stage_d.memwrite = 1'b0;
      stage_d.memtoreg = 1'b0;
    end else begin
      stage_d.valid    = 1'b1;
      stage_d.rs       = id_rs;
      stage_d.rt       = id_rt;
      stage_d.wr_reg   = id_regdst ? id_rd : id_rt;
      stage_d.rs_data  = id_rs_data;
      stage_d.rt_data  = id_rt_data;
      stage_d.imm      = id_imm;
      stage_d.alu_ctl  = id_alu_ctl;
      stage_d.alusrc   = id_alusrc;
      stage_d.regwrite = id_regwrite;
      stage_d.memread  = id_memread;
      stage_d.memwrite = id_memwrite;
      stage_d.memtoreg = id_memtoreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q         <= '0;
      stage_q.alu_ctl <= AluAdd;
    end else begin
      stage_q <= stage_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign stall = id_valid & stage_q.valid & stage_q.memread & (stage_q.wr_reg != 5'd0) &
                 ((stage_q.wr_reg == id_rs) | (stage_q.wr_reg == id_rt));

  always_comb begin
    fwd_rs = stage_q.rs_data;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == stage_q.rs)) begin
      fwd_rs = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == stage_q.rs)) begin
      fwd_rs = memwb_data;
    end
    fwd_rt = stage_q.rt_data;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == stage_q.rt)) begin
      fwd_rt = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == stage_q.rt)) begin
      fwd_rt = memwb_data;
    end
  end
`else
  logic ex_hit, exmem_hit;
  logic unused_fwd;

  assign ex_hit    = stage_q.valid & stage_q.regwrite & (stage_q.wr_reg != 5'd0) &
                     ((stage_q.wr_reg == id_rs) | (stage_q.wr_reg == id_rt));
  // Write-before-read register file makes MEM/WB producers safe without stalling.
  assign exmem_hit = exmem_regwrite & (exmem_rd != 5'd0) &
                     ((exmem_rd == id_rs) | (exmem_rd == id_rt));
  assign stall     = id_valid & (ex_hit | exmem_hit);

  assign fwd_rs = stage_q.rs_data;
  assign fwd_rt = stage_q.rt_data;

  assign unused_fwd = ^{exmem_result, memwb_regwrite, memwb_rd, memwb_data,
                        stage_q.rs, stage_q.rt};
`endif

  assign ex_valid      = stage_q.valid;
  assign alu_ctl       = stage_q.alu_ctl;
  assign alu_a         = fwd_rs;
  assign alu_b         = stage_q.alusrc ? stage_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_wr_reg     = stage_q.wr_reg;
  assign ex_regwrite   = stage_q.valid & stage_q.regwrite;
  assign ex_memread    = stage_q.valid & stage_q.memread;
  assign ex_memwrite   = stage_q.valid & stage_q.memwrite;
  assign ex_memtoreg   = stage_q.valid & stage_q.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FORWARD_EN if defined.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_alu_ctl;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        flush;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        stall, ex_valid;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_wr_reg;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_ctl(id_alu_ctl), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .stall(stall), .ex_valid(ex_valid), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .ex_wr_reg(ex_wr_reg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_ctl = 3'b010;
    id_alusrc = 0; id_regdst = 0; id_regwrite = 0;
    id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
  endtask

  task automatic clear_fwd;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) tick;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_ex_valid: got %h want 0", ex_valid); end
    n_cmp++; if (alu_ctl !== 3'b010) begin n_bad++;
      $display("FAIL rst_alu_ctl: got %b want 010", alu_ctl); end
    n_cmp++; if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 4'b0) begin n_bad++;
      $display("FAIL rst_ctl: got %b want 0000",
               {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}); end
    n_cmp++; if ({alu_a, alu_b, ex_wr_reg} !== '0) begin n_bad++;
      $display("FAIL rst_data: got a=%h b=%h wr=%0d want 0", alu_a, alu_b, ex_wr_reg); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++;
      $display("FAIL rst_stall: got %h want 0", stall); end
    // First edge after deassertion loads normally.
    rst = 0;
    id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_regdst = 1; id_regwrite = 1;
    id_alu_ctl = 3'b001; id_rs_data = 32'h11; id_rt_data = 32'h22;
    tick;
    n_cmp++; if ({ex_valid, ex_regwrite, alu_ctl, ex_wr_reg} !== {1'b1, 1'b1, 3'b001, 5'd3})
      begin n_bad++; $display("FAIL load_ctl: got v=%h rw=%h ctl=%b wr=%0d want 1 1 001 3",
                              ex_valid, ex_regwrite, alu_ctl, ex_wr_reg); end
    n_cmp++; if ({alu_a, alu_b} !== {32'h11, 32'h22}) begin n_bad++;
      $display("FAIL load_ops: got a=%h b=%h want 11 22", alu_a, alu_b); end
    // Mid-cycle asynchronous reset.
    clear_id;
    #3 rst = 1;
    #1;
    n_cmp++; if ({ex_valid, ex_regwrite, alu_ctl, ex_wr_reg} !== {1'b0, 1'b0, 3'b010, 5'd0})
      begin n_bad++; $display("FAIL async_rst: got v=%h rw=%h ctl=%b wr=%0d want 0 0 010 0",
                              ex_valid, ex_regwrite, alu_ctl, ex_wr_reg); end
    n_cmp++; if (alu_a !== 32'h0) begin n_bad++;
      $display("FAIL async_rst_a: got %h want 0", alu_a); end
    rst = 0;
    id_valid = 1; id_rs = 4; id_rt = 5; id_rd = 6; id_regdst = 0; id_memwrite = 1;
    id_alu_ctl = 3'b110; id_rs_data = 32'h44; id_rt_data = 32'h55;
    tick;
    n_cmp++; if ({ex_valid, ex_memwrite, alu_ctl, ex_wr_reg} !== {1'b1, 1'b1, 3'b110, 5'd5})
      begin n_bad++; $display("FAIL post_rst_load: got v=%h mw=%h ctl=%b wr=%0d want 1 1 110 5",
                              ex_valid, ex_memwrite, alu_ctl, ex_wr_reg); end
    clear_id;
  endtask

  task automatic test_back_to_back;
    // add $3,$1,$2
    id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_regdst = 1; id_regwrite = 1;
    id_alu_ctl = 3'b010; id_rs_data = 32'h7; id_rt_data = 32'h9;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++;
      $display("FAIL b2b_stall_add: got %h want 0", stall); end
    tick;
    // sub $4,$3,$1 with stale $3
    id_rs = 3; id_rt = 1; id_rd = 4; id_alu_ctl = 3'b110; id_rs_data = 32'h5; id_rt_data = 32'h7;
    #1;
`ifdef ID_EX_FORWARD_EN
    n_cmp++; if (stall !== 1'b0) begin n_bad++;
      $display("FAIL b2b_stall_sub: got %h want 0", stall); end
    tick;
    clear_id;
    exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h10;
    #1;
`else
    n_cmp++; if (stall !== 1'b1) begin n_bad++;
      $display("FAIL b2b_stall_ex: got %h want 1", stall); end
    tick;
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++;
      $display("FAIL b2b_bubble1: got %h want 0", ex_valid); end
    exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h10;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++;
      $display("FAIL b2b_stall_exmem: got %h want 1", stall); end
    tick;
    clear_fwd;
    memwb_regwrite = 1; memwb_rd = 3; memwb_data = 32'h10; id_rs_data = 32'h10;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++;
      $display("FAIL b2b_stall_memwb: got %h want 0", stall); end
    tick;
    clear_id;
    #1;
`endif
    n_cmp++; if ({alu_a, alu_b} !== {32'h10, 32'h7}) begin n_bad++;
      $display("FAIL b2b_ops: got a=%h b=%h want 10 7", alu_a, alu_b); end
    n_cmp++; if ({ex_valid, alu_ctl, ex_wr_reg} !== {1'b1, 3'b110, 5'd4}) begin n_bad++;
      $display("FAIL b2b_ctl: got v=%h ctl=%b wr=%0d want 1 110 4", ex_valid, alu_ctl, ex_wr_reg);
    end
    clear_fwd;
  endtask

  task automatic test_double_hazard;
    logic [31:0] exp_a1, exp_s1, exp_a2, exp_s2;
`ifdef ID_EX_FORWARD_EN
    exp_a1 = 32'hAAAA; exp_s1 = 32'hAAAA; exp_a2 = 32'hBBBB; exp_s2 = 32'hBBBB;
`else
    exp_a1 = 32'h1; exp_s1 = 32'h2; exp_a2 = 32'h1; exp_s2 = 32'h2;
`endif
    id_valid = 1; id_rs = 5; id_rt = 5; id_alusrc = 1; id_imm = 32'hFFFF_FFF0;
    id_rs_data = 32'h1; id_rt_data = 32'h2; id_memwrite = 1;
    tick;
    clear_id;
    exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'hAAAA;
    memwb_regwrite = 1; memwb_rd = 5; memwb_data = 32'hBBBB;
    #1;
    n_cmp++; if (alu_a !== exp_a1) begin n_bad++;
      $display("FAIL dbl_alu_a: got %h want %h", alu_a, exp_a1); end
    n_cmp++; if (ex_store_data !== exp_s1) begin n_bad++;
      $display("FAIL dbl_store: got %h want %h", ex_store_data, exp_s1); end
    n_cmp++; if (alu_b !== 32'hFFFF_FFF0) begin n_bad++;
      $display("FAIL dbl_alu_b_imm: got %h want fffffff0", alu_b); end
    exmem_rd = 7;
    #1;
    n_cmp++; if (alu_a !== exp_a2) begin n_bad++;
      $display("FAIL memwb_alu_a: got %h want %h", alu_a, exp_a2); end
    n_cmp++; if (ex_store_data !== exp_s2) begin n_bad++;
      $display("FAIL memwb_store: got %h want %h", ex_store_data, exp_s2); end
    clear_fwd;
  endtask

  task automatic test_zero_reg;
    id_valid = 1; id_rs = 0; id_rt = 0; id_rd = 0; id_regdst = 1; id_alu_ctl = 3'b001;
    id_rs_data = 32'h33; id_rt_data = 32'h44;
    tick;
    clear_id;
    exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
    memwb_regwrite = 1; memwb_rd = 0; memwb_data = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if ({alu_a, alu_b} !== {32'h33, 32'h44}) begin n_bad++;
      $display("FAIL zero_ops: got a=%h b=%h want 33 44", alu_a, alu_b); end
    n_cmp++; if (ex_store_data !== 32'h44) begin n_bad++;
      $display("FAIL zero_store: got %h want 44", ex_store_data); end
    clear_fwd;
  endtask

  task automatic test_load_use;
    // lw $6,4($1)
    id_valid = 1; id_rs = 1; id_rt = 6; id_regdst = 0; id_alusrc = 1; id_imm = 32'h4;
    id_memread = 1; id_memtoreg = 1; id_regwrite = 1; id_rs_data = 32'h100;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++;
      $display("FAIL lu_stall_pre: got %h want 0", stall); end
    tick;
    // add $7,$6,$2
    clear_id;
    id_valid = 1; id_rs = 6; id_rt = 2; id_rd = 7; id_regdst = 1; id_regwrite = 1;
    id_rs_data = 32'h99; id_rt_data = 32'h3;
    #1;
    n_cmp++; if ({ex_memread, ex_memtoreg, ex_wr_reg, alu_b} !== {1'b1, 1'b1, 5'd6, 32'h4})
      begin n_bad++; $display("FAIL lu_load_ex: got mr=%h mtr=%h wr=%0d b=%h want 1 1 6 4",
                              ex_memread, ex_memtoreg, ex_wr_reg, alu_b); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++;
      $display("FAIL lu_stall: got %h want 1", stall); end
    tick;
    n_cmp++; if ({ex_valid, ex_memread, ex_regwrite, alu_ctl} !== {3'b000, 3'b010})
      begin n_bad++; $display("FAIL lu_bubble: got v=%h mr=%h rw=%h ctl=%b want 0 0 0 010",
                              ex_valid, ex_memread, ex_regwrite, alu_ctl); end
    exmem_regwrite = 1; exmem_rd = 6; exmem_result = 32'h104;
    #1;
`ifdef ID_EX_FORWARD_EN
    n_cmp++; if (stall !== 1'b0) begin n_bad++;
      $display("FAIL lu_stall_once: got %h want 0", stall); end
    tick;
    clear_fwd;
`else
    n_cmp++; if (stall !== 1'b1) begin n_bad++;
      $display("FAIL lu_stall_exmem: got %h want 1", stall); end
    tick;
    clear_fwd;
    id_rs_data = 32'hCAFE;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++;
      $display("FAIL lu_stall_release: got %h want 0", stall); end
    tick;
`endif
    clear_id;
    memwb_regwrite = 1; memwb_rd = 6; memwb_data = 32'hCAFE;
    #1;
    n_cmp++; if ({ex_valid, ex_wr_reg} !== {1'b1, 5'd7}) begin n_bad++;
      $display("FAIL lu_dep_ex: got v=%h wr=%0d want 1 7", ex_valid, ex_wr_reg); end
    n_cmp++; if ({alu_a, alu_b} !== {32'hCAFE, 32'h3}) begin n_bad++;
      $display("FAIL lu_dep_ops: got a=%h b=%h want cafe 3", alu_a, alu_b); end
    clear_fwd;
  endtask

  task automatic test_flush_stall;
    // lw $8,0($1)
    id_valid = 1; id_rs = 1; id_rt = 8; id_alusrc = 1; id_memread = 1; id_memtoreg = 1;
    id_regwrite = 1;
    tick;
    clear_id;
    id_valid = 1; id_rs = 8; id_rt = 9; id_rd = 10; id_regdst = 1; id_regwrite = 1;
    id_memwrite = 1; id_alu_ctl = 3'b001; id_rs_data = 32'h1;
    flush = 1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++;
      $display("FAIL fs_stall: got %h want 1", stall); end
    tick;
    flush = 0;
    clear_id;
    #1;
    n_cmp++; if ({ex_valid, ex_regwrite, ex_memwrite} !== 3'b000) begin n_bad++;
      $display("FAIL fs_bubble: got v=%h rw=%h mw=%h want 0 0 0",
               ex_valid, ex_regwrite, ex_memwrite); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++;
      $display("FAIL fs_stall_after: got %h want 0", stall); end
    // Flush alone squashes a valid instruction.
    id_valid = 1; id_rs = 11; id_rt = 12; id_rd = 13; id_regdst = 1; id_regwrite = 1;
    flush = 1;
    tick;
    flush = 0;
    clear_id;
    #1;
    n_cmp++; if ({ex_valid, ex_regwrite} !== 2'b00) begin n_bad++;
      $display("FAIL flush_only: got v=%h rw=%h want 0 0", ex_valid, ex_regwrite); end
  endtask

  initial begin
    flush = 0;
    clear_id;
    clear_fwd;
    test_reset;
    test_back_to_back;
    test_double_hazard;
    test_zero_reg;
    test_load_use;
    test_flush_stall;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "bench timed out");
  end

endmodule
